// File: rtl/mtsp_scs_pkg.sv
// rtl/mtsp_scs_pkg.sv - shared op encoding for the MTSP scalar counter chain array
package mtsp_scs_pkg;

  localparam logic [1:0] SCS_LOAD = 2'b00;
  localparam logic [1:0] SCS_INC  = 2'b01;
  localparam logic [1:0] SCS_ADD  = 2'b10;
  localparam logic [1:0] SCS_CLR  = 2'b11;

  localparam int SCS_CHAIN_BIT = 3;
  localparam int SCS_EN_BIT    = 2;

  typedef struct packed {
    logic       chain;
    logic       en;
    logic [1:0] code;
  } scs_op_t;

endpackage

// File: rtl/mtsp_scs_lane.sv
// rtl/mtsp_scs_lane.sv - next-value and carry-out logic for one counter lane
module mtsp_scs_lane
  import mtsp_scs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  scs_op_t          op_i,
  input  logic [WIDTH-1:0] v_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] v_nxt_o,
  output logic             cout_o
);

  logic             eff_cin;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  always_comb begin
    // A chained lane takes its carry from below; otherwise INC supplies the +1.
    eff_cin = op_i.chain ? cin_i : (op_i.code == SCS_INC);
    addend  = (op_i.code == SCS_ADD) ? din_i : '0;
    sum     = {1'b0, v_i} + {1'b0, addend} + {{WIDTH{1'b0}}, eff_cin};
    v_nxt_o = v_i;
    cout_o  = 1'b0;
    if (op_i.en) begin
      case (op_i.code)
        SCS_LOAD: v_nxt_o = din_i;
        SCS_INC, SCS_ADD: begin
          v_nxt_o = sum[WIDTH-1:0];
          cout_o  = sum[WIDTH];
        end
        default:  v_nxt_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/mtsp_scs_chain_array.sv
// rtl/mtsp_scs_chain_array.sv - carry-chained counter lane array with 1-deep output register
// Optional saturation of overflowing segments: MTSP_SCS_SATURATE_EN.
module mtsp_scs_chain_array
  import mtsp_scs_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [4*LANES-1:0]     OP,
  input  logic [WIDTH*LANES-1:0] DIN,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [WIDTH*LANES-1:0] DOUT,
  output logic [LANES-1:0]       CARRY,
  output logic [LANES-1:0]       OVF
);

  logic [WIDTH*LANES-1:0] v_q, v_d, v_nxt_all;
  logic [LANES-1:0]       carry_q, ovf_q, ovf_d, cout_v, is_top, ovf_set;
  logic                   out_valid_q, out_valid_d, accept;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    scs_op_t          op;
    logic             cin;
    logic             cout;
    logic [WIDTH-1:0] v_nxt;

    assign op = scs_op_t'(OP[4*i +: 4]);
    if (i == 0) begin : g_first
      assign cin = (op.code == SCS_INC);
    end else begin : g_rest
      assign cin = g_lane[i-1].cout;
    end

    mtsp_scs_lane #(.WIDTH(WIDTH)) u_lane (
      .op_i    (op),
      .v_i     (v_q[WIDTH*i +: WIDTH]),
      .din_i   (DIN[WIDTH*i +: WIDTH]),
      .cin_i   (cin),
      .v_nxt_o (v_nxt),
      .cout_o  (cout)
    );

    assign v_nxt_all[WIDTH*i +: WIDTH] = v_nxt;
    assign cout_v[i] = cout;
  end

  // A lane tops its segment unless the lane above chains onto it.
  always_comb begin
    logic above;
    above = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      is_top[i] = ~above;
      above     = OP[4*i + SCS_CHAIN_BIT];
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ovf_set[i] = is_top[i] & OP[4*i + SCS_EN_BIT] & cout_v[i] &
                   ((OP[4*i +: 2] == SCS_INC) | (OP[4*i +: 2] == SCS_ADD));
      if (OP[4*i + SCS_EN_BIT] && (OP[4*i +: 2] == SCS_CLR))
        ovf_d[i] = 1'b0;
      else
        ovf_d[i] = ovf_q[i] | ovf_set[i];
    end
  end

`ifdef MTSP_SCS_SATURATE_EN
  // Walk down from each segment top so every member sees its top's overflow.
  always_comb begin
    logic run;
    run = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (is_top[i]) run = ovf_set[i];
      v_d[WIDTH*i +: WIDTH] = run ? {WIDTH{1'b1}} : v_nxt_all[WIDTH*i +: WIDTH];
    end
  end
`else
  assign v_d = v_nxt_all;
`endif

  assign IN_READY    = ~out_valid_q | OUT_READY;
  assign accept      = IN_VALID & IN_READY;
  assign out_valid_d = accept | (out_valid_q & ~OUT_READY);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q         <= '0;
      carry_q     <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        v_q     <= v_d;
        carry_q <= cout_v;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign DOUT      = v_q;
  assign CARRY     = carry_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_mtsp_scs_chain_array.sv
// tb/tb_mtsp_scs_chain_array.sv - scoreboard bench for mtsp_scs_chain_array (LANES=4, WIDTH=8)
module tb_mtsp_scs_chain_array;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] OP = '0;
  logic [31:0] DIN = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] DOUT;
  logic [3:0]  CARRY;
  logic [3:0]  OVF;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;
  logic [39:0] exp_q[$];

  mtsp_scs_chain_array #(.LANES(4), .WIDTH(8)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OP        (OP),
    .DIN       (DIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .DOUT      (DOUT),
    .CARRY     (CARRY),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST && OUT_VALID && OUT_READY) begin
      logic [39:0] e;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        chk($sformatf("dout#%0d", n_pop), DOUT, e[39:8]);
        chk($sformatf("carry#%0d", n_pop), {28'd0, CARRY}, {28'd0, e[7:4]});
        chk($sformatf("ovf#%0d", n_pop), {28'd0, OVF}, {28'd0, e[3:0]});
      end
    end
  end

  task automatic issue(input logic [15:0] op, input logic [31:0] din,
                       input logic [31:0] ed, input logic [3:0] ec, input logic [3:0] eo,
                       output int waited);
    waited = 0;
    OP = op;
    DIN = din;
    IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (!IN_READY) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back({ed, ec, eo});
      n_push++;
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_dout", DOUT, 32'h0);
    chk("rst_ovf", {28'd0, OVF}, 32'h0);
    chk("rst_carry", {28'd0, CARRY}, 32'h0);
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'h0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'h1);
    @(posedge CLK);
    #1;

    issue(16'h4444, 32'h000000FF, 32'h000000FF, 4'b0000, 4'b0000, w);
    issue(16'h5555, 32'h00000000, 32'h01010100, 4'b0001, 4'b0001, w);
    chk("b2b_wait", w, 0);
    issue(16'h7777, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, w);
    issue(16'h4444, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 4'b0000, w);
`ifdef MTSP_SCS_SATURATE_EN
    issue(16'hDDD5, 32'h00000000, 32'hFFFFFFFF, 4'b1111, 4'b1000, w);
`else
    issue(16'hDDD5, 32'h00000000, 32'h00000000, 4'b1111, 4'b1000, w);
`endif
    issue(16'h4444, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 4'b1000, w);
    issue(16'hD9D5, 32'h00000000, 32'hFFFF0000, 4'b0011, 4'b1000, w);
    issue(16'h7744, 32'h00000190, 32'h00000190, 4'b0000, 4'b0000, w);
    issue(16'h00E6, 32'h00000180, 32'h00000310, 4'b0001, 4'b0000, w);
`ifdef MTSP_SCS_SATURATE_EN
    issue(16'h00E6, 32'h0000FCF0, 32'h0000FFFF, 4'b0011, 4'b0010, w);
    issue(16'h0070, 32'h00000000, 32'h000000FF, 4'b0000, 4'b0000, w);
`else
    issue(16'h00E6, 32'h0000FCF0, 32'h00000000, 4'b0011, 4'b0010, w);
    issue(16'h0070, 32'h00000000, 32'h00000000, 4'b0000, 4'b0000, w);
`endif

    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    issue(16'h4444, 32'h11223344, 32'h11223344, 4'b0000, 4'b0000, w);
    OP = 16'h5555;
    DIN = 32'h0;
    IN_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("stall_in_ready%0d", k), {31'd0, IN_READY}, 32'h0);
      chk($sformatf("stall_out_valid%0d", k), {31'd0, OUT_VALID}, 32'h1);
      chk($sformatf("stall_dout%0d", k), DOUT, 32'h11223344);
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    issue(16'h5555, 32'h00000000, 32'h12233445, 4'b0000, 4'b0000, w);
    chk("release_wait", w, 0);
    issue(16'h5555, 32'h00000000, 32'h13243546, 4'b0000, 4'b0000, w);
    chk("throughput_wait", w, 0);
    @(negedge CLK);
    chk("throughput_out_valid", {31'd0, OUT_VALID}, 32'h1);
    repeat (3) @(posedge CLK);
    #1;
    chk("drain_queue", exp_q.size(), 0);
    chk("push_pop", n_pop, n_push);

    OUT_READY = 1'b0;
    issue(16'h4444, 32'hAABBCCDD, 32'hAABBCCDD, 4'b0000, 4'b0000, w);
    #2;
    nRST = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, OUT_VALID}, 32'h0);
    chk("async_dout", DOUT, 32'h0);
    chk("async_in_ready", {31'd0, IN_READY}, 32'h1);
    exp_q.delete();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("post_rst_out_valid", {31'd0, OUT_VALID}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
